shift_reg_cmd_sequencer: RTL and testbench

Upstream control stage for the load/shift-left/shift-right register. It accepts queued commands over a valid/ready handshake and buffers them in a small FIFO. Each command expands into a cycle-accurate stream of load / shift_left_right / shift_en / data_in controls. This replaces hand-timed testbench tasks with a synthesizable driver that runs back-to-back commands with no bubbles.

---
 rtl/shift_reg_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_shift_reg_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_cmd_sequencer.sv
// Command sequencer for the load/shift register: buffers {op,data,count} commands
// in a small FIFO and expands each into a registered, bubble-free control stream.
module shift_reg_cmd_sequencer #(
    parameter int REG_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [REG_WIDTH-1:0]               cmd_data,
    input  logic [CNT_WIDTH-1:0]               cmd_count,
    output logic                               load,
    output logic                               shift_left_right,
    output logic                               shift_en,
    output logic [REG_WIDTH-1:0]               data_in,
    output logic                               done,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    op_e                  op_mem   [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] cnt_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop;

    state_e               state, state_n;
    op_e                  cur_op, cur_op_n;
    logic [REG_WIDTH-1:0] cur_data, cur_data_n;
    logic [CNT_WIDTH-1:0] rem, rem_n;

    logic                 load_n, slr_n, sen_n, done_n;
    logic [REG_WIDTH-1:0] din_n;

    op_e                  head_op;
    logic [REG_WIDTH-1:0] head_data;
    logic [CNT_WIDTH-1:0] head_count;

    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    // Pop only uses the pre-edge level, so a push into an empty FIFO waits one edge.
    assign pop       = !empty && ((state == S_IDLE) || (rem == '0));
    assign busy      = (state == S_RUN) || !empty;

    assign head_op    = op_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign head_count = cnt_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= op_e'(cmd_op);
            data_mem[wr_ptr] <= cmd_data;
            cnt_mem[wr_ptr]  <= cmd_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_op   <= OP_NOP;
            cur_data <= '0;
            rem      <= '0;
        end else begin
            state    <= state_n;
            cur_op   <= cur_op_n;
            cur_data <= cur_data_n;
            rem      <= rem_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_op_n   = cur_op;
        cur_data_n = cur_data;
        rem_n      = rem;
        if (pop) begin
            state_n    = S_RUN;
            cur_op_n   = head_op;
            cur_data_n = head_data;
            rem_n      = (head_op == OP_LOAD) ? '0 : head_count;
        end else if (state == S_RUN) begin
            if (rem != '0) rem_n = rem - 1'b1;
            else           state_n = S_IDLE;
        end
    end

    // Control outputs are registered, so they trail the FSM state by one cycle.
    always_comb begin
        load_n = 1'b0;
        slr_n  = 1'b0;
        sen_n  = 1'b0;
        din_n  = '0;
        done_n = 1'b0;
        if (state == S_RUN) begin
            done_n = (rem == '0);
            unique case (cur_op)
                OP_LOAD: begin
                    load_n = 1'b1;
                    din_n  = cur_data;
                end
                OP_SHL: begin
                    sen_n = 1'b1;
                    slr_n = 1'b1;
                end
                OP_SHR:  sen_n = 1'b1;
                OP_NOP:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load             <= 1'b0;
            shift_left_right <= 1'b0;
            shift_en         <= 1'b0;
            data_in          <= '0;
            done             <= 1'b0;
        end else begin
            load             <= load_n;
            shift_left_right <= slr_n;
            shift_en         <= sen_n;
            data_in          <= din_n;
            done             <= done_n;
        end
    end

endmodule

// File: tb/tb_shift_reg_cmd_sequencer.sv
// Scoreboard bench: each accepted command enqueues time-stamped expected control words;
// a negedge monitor compares every cycle (idle cycles must be all-zero).
module tb_shift_reg_cmd_sequencer;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic          load, shift_left_right, shift_en, done, busy;
    logic [W-1:0]  data_in;
    logic [2:0]    fifo_level;

    shift_reg_cmd_sequencer #(.REG_WIDTH(W), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .load(load), .shift_left_right(shift_left_right), .shift_en(shift_en),
        .data_in(data_in), .done(done), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t;
        logic [11:0] w;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] wd(logic ld, logic slr, logic sen, logic [W-1:0] d, logic dn);
        return {ld, slr, sen, d, dn};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [11:0] e, g;
            e = '0;
            if (q.size() > 0 && q[0].t == cyc) begin
                exp_t x;
                x = q.pop_front();
                e = x.w;
            end
            g = {load, shift_left_right, shift_en, data_in, done};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%h expected=%h", cyc, g, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Returns the accepting edge index in t, and the first expected output stamp in st.
    task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] d, input logic [CW-1:0] c,
                            output int unsigned t, output int unsigned st);
        int unsigned n;
        int unsigned tries = 0;
        t = 0; st = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
        while (!cmd_ready) begin
            tries++;
            if (tries > 200) begin
                errors++;
                $display("FAIL push_timeout got=busy expected=accept");
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t  = cyc;
        n  = (op == 2'b00) ? 1 : int'(c) + 1;
        st = (t + 2 > next_free) ? t + 2 : next_free;
        for (int unsigned i = 0; i < n; i++) begin
            exp_t x;
            logic last;
            last = (i == n - 1);
            x.t = st + i;
            case (op)
                2'b00:   x.w = wd(1'b1, 1'b0, 1'b0, d, 1'b1);
                2'b01:   x.w = wd(1'b0, 1'b1, 1'b1, '0, last);
                2'b10:   x.w = wd(1'b0, 1'b0, 1'b1, '0, last);
                default: x.w = wd(1'b0, 1'b0, 1'b0, '0, last);
            endcase
            q.push_back(x);
        end
        next_free = st + n;
    endtask

    task automatic drain();
        int unsigned k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            k++;
            if (k > 300) begin
                errors++;
                $display("FAIL drain_timeout got=%0d expected=0", q.size());
                q.delete();
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_after_edge(input int unsigned e);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int unsigned t, st, t0, t1, st1, t5;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {load, shift_left_right, shift_en, data_in, done}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Single LOAD: latency 2 edges, done on the lone cycle
        push_cmd(2'b00, 8'hA5, 4'd0, t, st);
        chk("load_latency", st, t + 2);
        drain();
        chk("idle_busy_1", busy, 0);

        push_cmd(2'b01, 8'h00, 4'd3, t, st);
        drain();

        // Back-to-back: LOAD 01, SHR x1, LOAD FF with no gaps
        push_cmd(2'b00, 8'h01, 4'd0, t0, st1);
        push_cmd(2'b10, 8'h00, 4'd0, t, st);
        chk("b2b_shr_start", st, st1 + 1);
        push_cmd(2'b00, 8'hFF, 4'd0, t, st);
        chk("b2b_ld_start", st, st1 + 2);
        drain();

        // Fill the FIFO behind a long NOP
        push_cmd(2'b11, 8'h00, 4'd15, t0, st);
        push_cmd(2'b00, 8'h11, 4'd0, t, st1);
        push_cmd(2'b01, 8'h00, 4'd1, t, st);
        push_cmd(2'b10, 8'h00, 4'd2, t, st);
        push_cmd(2'b00, 8'h22, 4'd0, t, st);
        chk("full_level", fifo_level, 4);
        chk("full_ready", cmd_ready, 0);
        push_cmd(2'b11, 8'h00, 4'd0, t5, st);
        chk("held_accept", t5, st1);
        chk("nop_len", st1, t0 + 2 + 16);
        drain();
        chk("idle_busy_2", busy, 0);

        // Reset in the middle of a long shift-right
        push_cmd(2'b10, 8'h00, 4'd10, t, st);
        wait_after_edge(t + 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        next_free = 0;
        chk("midrst_level", fifo_level, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        reset = 1'b0;
        push_cmd(2'b00, 8'h3C, 4'd0, t, st);
        chk("post_rst_latency", st, t + 2);
        drain();

        // Simultaneous push and pop at level 2
        push_cmd(2'b01, 8'h00, 4'd5, t0, st);
        push_cmd(2'b00, 8'h5A, 4'd0, t, st);
        push_cmd(2'b00, 8'h6B, 4'd0, t, st);
        wait_after_edge(t0 + 6);
        chk("pre_pp_level", fifo_level, 2);
        push_cmd(2'b00, 8'h7C, 4'd0, t, st);
        chk("pp_edge", t, t0 + 7);
        chk("pp_level", fifo_level, 2);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] dv;
            dv = W'(8'h81 + 8'(i * 17));
            push_cmd(2'b00, dv, 4'd0, t, st);
        end
        push_cmd(2'b01, 8'h00, 4'hF, t, st);
        drain();
        chk("final_busy", busy, 0);
        chk("final_level", fifo_level, 0);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
